// File: rtl/mole_round_controller_if.sv
// rtl/mole_round_controller_if.sv - game/hit inputs and mole/score/judgement outputs of the round controller
interface mole_round_controller_if #(
    parameter int unsigned NUM_MOLES   = 3,
    parameter int unsigned SCORE_WIDTH = 8
) ();
    logic                   game;
    logic [NUM_MOLES-1:0]   hit;
    logic [NUM_MOLES-1:0]   mole;
    logic [SCORE_WIDTH-1:0] score;
    logic [1:0]             level;
    logic                   hit_ok;
    logic                   miss;

    modport master (
        output game, hit,
        input  mole, score, level, hit_ok, miss
    );

    modport slave (
        input  game, hit,
        output mole, score, level, hit_ok, miss
    );
endinterface

// File: rtl/mole_round_controller.sv
// rtl/mole_round_controller.sv - gap/up round FSM, non-repeating mole picker, scorer and level decode for N moles
module mole_round_controller #(
    parameter int unsigned           NUM_MOLES   = 3,
    parameter int unsigned           SCORE_WIDTH = 8,
    parameter int unsigned           LFSR_WIDTH  = 8,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS   = 8'hB8,
    parameter int unsigned           GAP_CYCLES  = 150000000,
    parameter int unsigned           UP_CYCLES   = 200000000,
    parameter int unsigned           THRESH1     = 3,
    parameter int unsigned           THRESH2     = 6,
    parameter int unsigned           THRESH3     = 11
) (
    input  logic                  clock,
    input  logic                  reset,
    mole_round_controller_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GAP  = 2'd1;
    localparam logic [1:0] S_UP   = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [31:0]            counter_q, counter_d;
    logic [LFSR_WIDTH-1:0]  lfsr_q, lfsr_d, lfsr_next;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic [NUM_MOLES-1:0]   mole_q, mole_d;
    logic [IDX_W-1:0]       prev_idx_q, prev_idx_d;
    logic                   first_q, first_d;
    logic                   hit_ok_q, hit_ok_d;
    logic                   miss_q, miss_d;

    logic [IDX_W-1:0]       cand, idx;
    logic [1:0]             level;
    logic [31:0]            up_time;
    logic                   hit_match, hit_wrong;

    always_comb begin
        lfsr_next = {lfsr_q[LFSR_WIDTH-2:0], ~^(lfsr_q & LFSR_TAPS)};

        // The repeat rule needs a previous mole, so it is skipped on the first round of a game.
        cand = IDX_W'(32'(lfsr_q) % NUM_MOLES);
        idx  = cand;
        if (!first_q && cand == prev_idx_q)
            idx = (32'(cand) == NUM_MOLES - 1) ? '0 : cand + IDX_W'(1);

        if (32'(score_q) < THRESH1)
            level = 2'd0;
        else if (32'(score_q) < THRESH2)
            level = 2'd1;
        else if (32'(score_q) < THRESH3)
            level = 2'd2;
        else
            level = 2'd3;

        up_time   = UP_CYCLES >> level;
        hit_match = (bus.hit == mole_q);
        hit_wrong = |(bus.hit & ~mole_q);
    end

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        lfsr_d     = lfsr_q;
        score_d    = score_q;
        mole_d     = mole_q;
        prev_idx_d = prev_idx_q;
        first_d    = first_q;
        hit_ok_d   = 1'b0;
        miss_d     = 1'b0;

        if (!bus.game) begin
            state_d    = S_IDLE;
            counter_d  = '0;
            lfsr_d     = '0;
            score_d    = '0;
            mole_d     = '0;
            prev_idx_d = '0;
            first_d    = 1'b1;
        end else begin
            lfsr_d = lfsr_next;
            case (state_q)
                S_IDLE: begin
                    // The start-up gap also covers the cycle in which game was first seen.
                    state_d   = S_GAP;
                    counter_d = GAP_CYCLES;
                end
                S_GAP: begin
                    if (counter_q == '0) begin
                        state_d    = S_UP;
                        counter_d  = up_time - 32'd1;
                        mole_d     = NUM_MOLES'(1) << idx;
                        prev_idx_d = idx;
                        first_d    = 1'b0;
                    end else begin
                        counter_d = counter_q - 32'd1;
                    end
                end
                S_UP: begin
                    if (hit_match) begin
                        score_d   = (score_q == '1) ? score_q : score_q + SCORE_WIDTH'(1);
                        hit_ok_d  = 1'b1;
                        mole_d    = '0;
                        state_d   = S_GAP;
                        counter_d = GAP_CYCLES - 32'd1;
                    end else begin
                        if (hit_wrong && score_q != '0)
                            score_d = score_q - SCORE_WIDTH'(1);
                        if (counter_q == '0) begin
                            miss_d    = 1'b1;
                            mole_d    = '0;
                            state_d   = S_GAP;
                            counter_d = GAP_CYCLES - 32'd1;
                        end else begin
                            counter_d = counter_q - 32'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            counter_q  <= '0;
            lfsr_q     <= '0;
            score_q    <= '0;
            mole_q     <= '0;
            prev_idx_q <= '0;
            first_q    <= 1'b1;
            hit_ok_q   <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            lfsr_q     <= lfsr_d;
            score_q    <= score_d;
            mole_q     <= mole_d;
            prev_idx_q <= prev_idx_d;
            first_q    <= first_d;
            hit_ok_q   <= hit_ok_d;
            miss_q     <= miss_d;
        end
    end

    assign bus.mole   = mole_q;
    assign bus.score  = score_q;
    assign bus.level  = level;
    assign bus.hit_ok = hit_ok_q;
    assign bus.miss   = miss_q;
endmodule

// File: tb/tb_mole_round_controller.sv
// tb/tb_mole_round_controller.sv - scoreboard bench for mole_round_controller with 3 moles and short timings
module tb_mole_round_controller;
    localparam int NM  = 3;
    localparam int SW  = 4;
    localparam int GAP = 4;
    localparam int UP  = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mole_round_controller_if #(.NUM_MOLES(NM), .SCORE_WIDTH(SW)) bus ();

    mole_round_controller #(
        .NUM_MOLES(NM), .SCORE_WIDTH(SW), .GAP_CYCLES(GAP), .UP_CYCLES(UP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int            cyc;
        logic [NM-1:0] mole;
        logic [SW-1:0] score;
        logic [1:0]    level;
        logic          hit_ok;
        logic          miss;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference generator: the documented XNOR LFSR, cleared whenever game is low.
    logic [7:0] m_lfsr = 8'd0;
    always @(posedge clock) begin
        if (reset || !bus.game) m_lfsr <= 8'd0;
        else                    m_lfsr <= {m_lfsr[6:0], ~^(m_lfsr & 8'hB8)};
    end

    bit            mon_en     = 0;
    bit            track      = 0;
    logic [NM-1:0] last_mole  = '0;
    logic [SW-1:0] last_score = '0;
    int            last_idx   = -1;
    int            repeats    = 0;
    logic [NM-1:0] seen       = '0;

    always @(negedge clock) begin
        ev_t e;
        int  ix;
        if (mon_en) begin
            if (bus.mole !== last_mole || bus.score !== last_score || bus.hit_ok !== 1'b0 || bus.miss !== 1'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event cyc=%0d got mole=%b score=%0d hit_ok=%b miss=%b, required no event",
                             cyc, bus.mole, bus.score, bus.hit_ok, bus.miss);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || bus.mole !== e.mole || bus.score !== e.score || bus.level !== e.level ||
                        bus.hit_ok !== e.hit_ok || bus.miss !== e.miss) begin
                        n_fail++;
                        $display("FAIL event got cyc=%0d mole=%b score=%0d level=%0d hit_ok=%b miss=%b, required cyc=%0d mole=%b score=%0d level=%0d hit_ok=%b miss=%b",
                                 cyc, bus.mole, bus.score, bus.level, bus.hit_ok, bus.miss,
                                 e.cyc, e.mole, e.score, e.level, e.hit_ok, e.miss);
                    end
                end
            end
            if (track && bus.mole != '0 && bus.mole !== last_mole) begin
                ix = -1;
                for (int i = 0; i < NM; i++) if (bus.mole[i]) ix = i;
                if (ix == last_idx) repeats++;
                last_idx = ix;
                seen     = seen | bus.mole;
            end
            last_mole  = bus.mole;
            last_score = bus.score;
        end
    end

    int   b_score = 0;
    int   b_prev  = 0;
    int   b_idx   = 0;
    int   up_at   = 0;
    int   expire  = 0;
    bit   b_first = 1;

    function automatic logic [1:0] lvl(int s);
        if (s < 3)  return 2'd0;
        if (s < 6)  return 2'd1;
        if (s < 11) return 2'd2;
        return 2'd3;
    endfunction

    task automatic push(int c, logic [NM-1:0] m, int s, logic ho, logic mi);
        ev_t e;
        e.cyc = c; e.mole = m; e.score = SW'(s); e.level = lvl(s); e.hit_ok = ho; e.miss = mi;
        exp_q.push_back(e);
    endtask

    task automatic chk(string nm, int got, int req);
        n_cmp++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s got %0d required %0d", nm, got, req);
        end
    endtask

    task automatic wait_to(int e);
        while (cyc < e) @(negedge clock);
    endtask

    task automatic start_game();
        bus.game = 1'b1;
        b_first  = 1;
        up_at    = cyc + 2 + GAP;
    endtask

    task automatic await_mole();
        int cand;
        wait_to(up_at - 1);
        cand = int'(m_lfsr) % NM;
        if (!b_first && cand == b_prev) cand = (cand + 1) % NM;
        b_prev  = cand;
        b_first = 0;
        b_idx   = cand;
        push(up_at, NM'(1) << cand, b_score, 1'b0, 1'b0);
        expire = up_at + (UP >> lvl(b_score));
        wait_to(up_at);
    endtask

    task automatic pulse(logic [NM-1:0] h);
        bus.hit = h;
        @(negedge clock);
        bus.hit = '0;
    endtask

    task automatic hit_correct();
        b_score = (b_score == 15) ? 15 : b_score + 1;
        push(cyc + 1, '0, b_score, 1'b1, 1'b0);
        up_at = cyc + 1 + GAP;
        pulse(NM'(1) << b_idx);
    endtask

    task automatic hit_wrong(bit with_correct);
        logic [NM-1:0] h;
        h = NM'(1) << ((b_idx + 1) % NM);
        if (with_correct) h = h | (NM'(1) << b_idx);
        if (b_score > 0) begin
            b_score--;
            push(cyc + 1, NM'(1) << b_idx, b_score, 1'b0, 1'b0);
        end
        pulse(h);
    endtask

    task automatic do_miss();
        push(expire, '0, b_score, 1'b0, 1'b1);
        up_at = expire + GAP;
        wait_to(expire);
    endtask

    initial begin
        bus.game = 1'b0;
        bus.hit  = '0;
        reset    = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_mole",   int'(bus.mole),   0);
        chk("reset_score",  int'(bus.score),  0);
        chk("reset_level",  int'(bus.level),  0);
        chk("reset_hit_ok", int'(bus.hit_ok), 0);
        chk("reset_miss",   int'(bus.miss),   0);
        mon_en = 1;

        // Idle: hits are ignored while game is low.
        for (int i = 0; i < 6; i++) pulse((i % 2 == 0) ? 3'b111 : NM'(1) << (i % NM));
        chk("idle_score", int'(bus.score), 0);
        chk("idle_mole",  int'(bus.mole),  0);

        // Round timing and a miss.
        start_game();
        await_mole();
        do_miss();
        await_mole();

        // Wrong hit at score 0, then a correct hit, then ignored hits in the gap.
        hit_wrong(0);
        hit_correct();
        pulse(3'b111);
        pulse(3'b111);

        await_mole(); hit_correct();
        await_mole(); hit_wrong(1);
        hit_correct();
        await_mole(); hit_correct();

        // Level 1 halves the visible time.
        await_mole(); do_miss();
        for (int i = 0; i < 8; i++) begin
            await_mole();
            hit_correct();
        end

        // Level 3: two visible cycles, and a hit on the last one still counts.
        await_mole(); do_miss();
        await_mole();
        wait_to(up_at + 1);
        hit_correct();
        for (int i = 0; i < 3; i++) begin
            await_mole();
            hit_correct();
        end
        await_mole(); hit_correct();
        chk("saturated_score", b_score, 15);

        // Abort mid-UP.
        await_mole();
        bus.game = 1'b0;
        b_score  = 0;
        push(cyc + 1, '0, 0, 1'b0, 1'b0);
        repeat (4) @(negedge clock);

        // Reset mid-GAP, then a long run to check the no-repeat rule.
        start_game();
        await_mole(); hit_correct();
        @(negedge clock);
        reset   = 1'b1;
        b_score = 0;
        push(cyc + 1, '0, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        reset   = 1'b0;
        b_first = 1;
        up_at   = cyc + 2 + GAP;

        track = 1;
        for (int i = 0; i < 300; i++) begin
            await_mole();
            do_miss();
        end
        track = 0;
        chk("no_repeat",   repeats,     0);
        chk("all_indices", int'(seen),  7);

        bus.game = 1'b0;
        repeat (4) @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog cyc=%0d required completion before 200000 cycles", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1);
    end
endmodule
